// File: rtl/timer_if.sv
// Register-bus bundle for the timer: address/write strobe/data in,
// combinational read data and interrupt request out.
interface timer_if #(
  parameter int DATA_W = 32
);
  logic [1:0]        addr;
  logic              WE;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dataOut;
  logic              IRQ;

  modport master (
    output addr,
    output WE,
    output din,
    input  dataOut,
    input  IRQ
  );

  modport slave (
    input  addr,
    input  WE,
    input  din,
    output dataOut,
    output IRQ
  );
endinterface

// File: rtl/timer.sv
// Down-counting timer with CTRL/PRESET/COUNT registers.
// Mode 1 auto-reloads and pulses the interrupt for one cycle; every other
// mode is one-shot, clears Enable and leaves the interrupt pending until
// software writes CTRL or PRESET.
module timer #(
  parameter int DATA_W = 32
) (
  input  logic   clk,
  input  logic   reset,
  timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [3:0]        ctrl;
  logic [DATA_W-1:0] preset;
  logic [DATA_W-1:0] count;
  logic              irq_flag;

  logic              en;
  logic [1:0]        mode;
  logic              im;

  logic              wr_ctrl;
  logic              wr_preset;

  logic              count_load;
  logic              count_dec;
  logic              count_zero;
  logic              irq_set;
  logic              irq_clr_hw;
  logic              en_clr_hw;

  assign en   = ctrl[0];
  assign mode = ctrl[2:1];
  assign im   = ctrl[3];

  // Only CTRL and PRESET are writable; addresses 2 and 3 drop writes.
  assign wr_ctrl   = bus.WE && (bus.addr == 2'd0);
  assign wr_preset = bus.WE && (bus.addr == 2'd1);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-state datapath controls.
  always_comb begin
    state_nxt  = state;
    count_load = 1'b0;
    count_dec  = 1'b0;
    count_zero = 1'b0;
    irq_set    = 1'b0;
    irq_clr_hw = 1'b0;
    en_clr_hw  = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        count_load = 1'b1;
        state_nxt  = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count > DATA_W'(1)) begin
          count_dec = 1'b1;
        end else begin
          // Terminal count: also covers PRESET=0, so no wrap below zero.
          count_zero = 1'b1;
          irq_set    = 1'b1;
          state_nxt  = INT;
        end
      end
      INT: begin
        if (mode == 2'd1) begin
          irq_clr_hw = 1'b1;
        end else begin
          en_clr_hw  = 1'b1;
        end
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // CTRL: a software write on the same edge beats the hardware Enable clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= 4'd0;
    end else if (wr_ctrl) begin
      ctrl <= bus.din[3:0];
    end else if (en_clr_hw) begin
      ctrl[0] <= 1'b0;
    end
  end

  // PRESET: only sampled into COUNT during LOAD, so mid-count writes are deferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      preset <= '0;
    end else if (wr_preset) begin
      preset <= bus.din;
    end
  end

  // COUNT: loaded, decremented or forced to zero by the FSM; otherwise held.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (count_load) begin
      count <= preset;
    end else if (count_dec) begin
      count <= count - DATA_W'(1);
    end else if (count_zero) begin
      count <= '0;
    end
  end

  // Interrupt flag: any CTRL/PRESET write acknowledges it, ahead of the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_flag <= 1'b0;
    end else if (wr_ctrl || wr_preset) begin
      irq_flag <= 1'b0;
    end else if (irq_set) begin
      irq_flag <= 1'b1;
    end else if (irq_clr_hw) begin
      irq_flag <= 1'b0;
    end
  end

  // Combinational register read and masked interrupt output.
  always_comb begin
    bus.dataOut = '0;
    case (bus.addr)
      2'd0:    bus.dataOut = {{(DATA_W-4){1'b0}}, ctrl};
      2'd1:    bus.dataOut = preset;
      2'd2:    bus.dataOut = count;
      default: bus.dataOut = '0;
    endcase
    bus.IRQ = im & irq_flag;
  end

endmodule

// File: tb/tb_timer.sv
// Scoreboard bench for the timer: the driver pushes the expected read data
// and IRQ for every cycle from a behavioural model; a monitor pops and
// compares them against the DUT once per cycle.
module tb_timer;

  localparam int S_IDLE = 0;
  localparam int S_LOAD = 1;
  localparam int S_CNT  = 2;
  localparam int S_INT  = 3;

  logic clk;
  logic reset;

  timer_if #(.DATA_W(32)) bus ();

  timer #(.DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [3:0]  m_ctrl;
  logic [31:0] m_pre;
  logic [31:0] m_cnt;
  logic        m_irq;
  int          m_st;

  typedef struct {
    logic [31:0] data;
    logic        irq;
    logic [1:0]  addr;
  } exp_t;

  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_ctrl};
      2'd1:    return m_pre;
      2'd2:    return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer, written as "state rules then software wins".
  task automatic model_step(input logic r, input logic w, input logic [1:0] a,
                            input logic [31:0] d);
    logic [3:0]  n_ctrl;
    logic [31:0] n_pre;
    logic [31:0] n_cnt;
    logic        n_irq;
    int          n_st;
    if (r) begin
      m_ctrl = 4'd0; m_pre = 32'd0; m_cnt = 32'd0; m_irq = 1'b0; m_st = S_IDLE;
      return;
    end
    n_ctrl = m_ctrl; n_pre = m_pre; n_cnt = m_cnt; n_irq = m_irq; n_st = m_st;
    if (m_st == S_IDLE) begin
      if (m_ctrl[0]) n_st = S_LOAD;
    end else if (m_st == S_LOAD) begin
      n_cnt = m_pre;
      n_st  = S_CNT;
    end else if (m_st == S_CNT) begin
      if (!m_ctrl[0]) n_st = S_IDLE;
      else if (m_cnt > 1) n_cnt = m_cnt - 1;
      else begin
        n_cnt = 0; n_irq = 1'b1; n_st = S_INT;
      end
    end else begin
      if (m_ctrl[2:1] == 2'd1) n_irq = 1'b0;
      else n_ctrl[0] = 1'b0;
      n_st = S_IDLE;
    end
    if (w && a == 2'd0) begin
      n_ctrl = d[3:0]; n_irq = 1'b0;
    end
    if (w && a == 2'd1) begin
      n_pre = d; n_irq = 1'b0;
    end
    m_ctrl = n_ctrl; m_pre = n_pre; m_cnt = n_cnt; m_irq = n_irq; m_st = n_st;
  endtask

  // Drive one cycle: record what the DUT must show this cycle, then advance the model.
  task automatic cyc(input logic r, input logic w, input logic [1:0] a,
                     input logic [31:0] d);
    exp_t e;
    @(negedge clk);
    reset    = r;
    bus.WE   = w;
    bus.addr = a;
    bus.din  = d;
    e.data = model_read(a);
    e.irq  = m_ctrl[3] & m_irq;
    e.addr = a;
    exp_q.push_back(e);
    model_step(r, w, a, d);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, a, $urandom);
  endtask

  // Monitor: compare once per cycle, in the middle of the low phase.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (bus.dataOut !== e.data) begin
        n_bad++;
        $display("FAIL read addr=%0d: got %h expected %h at %0t", e.addr, bus.dataOut, e.data, $time);
      end
      n_cmp++;
      if (bus.IRQ !== e.irq) begin
        n_bad++;
        $display("FAIL irq: got %b expected %b at %0t", bus.IRQ, e.irq, $time);
      end
    end
  end

  initial begin
    logic        w;
    logic [1:0]  a;
    logic [31:0] d;
    reset = 1'b1; bus.WE = 1'b0; bus.addr = 2'd0; bus.din = 32'd0;
    m_ctrl = 4'd0; m_pre = 32'd0; m_cnt = 32'd0; m_irq = 1'b0; m_st = S_IDLE;

    // Reset, with writes attempted under reset
    cyc(1'b1, 1'b1, 2'd0, 32'hFFFF_FFFF);
    cyc(1'b1, 1'b1, 2'd1, 32'h1234_5678);
    for (int i = 0; i < 4; i++) rd(2'(i), 1);

    // One-shot mode: PRESET=5, CTRL=IM|EN, watch COUNT then CTRL, then acknowledge
    wr(2'd1, 32'd5);
    wr(2'd0, 32'hFFFF_FFF9);
    rd(2'd2, 10);
    rd(2'd0, 3);
    wr(2'd0, 32'h8);
    rd(2'd0, 2);

    // Auto-reload mode: CTRL=IM|Mode1|EN, watch COUNT and IRQ over several periods
    wr(2'd0, 32'hB);
    rd(2'd2, 28);
    rd(2'd0, 4);

    // Masked interrupt, then setting IM by a write that also acknowledges
    wr(2'd0, 32'h0);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    rd(2'd2, 8);
    rd(2'd3, 1);
    wr(2'd0, 32'h8);
    rd(2'd0, 3);

    // Freeze mid-count, PRESET change mid-count, re-enable reloads
    wr(2'd1, 32'd20);
    wr(2'd0, 32'h9);
    rd(2'd2, 6);
    wr(2'd1, 32'd7);
    rd(2'd2, 3);
    wr(2'd0, 32'h8);
    rd(2'd2, 4);
    wr(2'd0, 32'h9);
    rd(2'd2, 12);

    // PRESET=0 behaves as 1; CTRL write lands on the INT edge
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    rd(2'd2, 6);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    rd(2'd2, 3);
    wr(2'd0, 32'hF);
    rd(2'd0, 4);

    // Reset mid-count and reset in INT
    wr(2'd1, 32'd9);
    wr(2'd0, 32'h9);
    rd(2'd2, 5);
    cyc(1'b1, 1'b0, 2'd2, 32'd0);
    rd(2'd2, 1);
    rd(2'd0, 1);
    rd(2'd1, 1);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hB);
    rd(2'd2, 3);
    cyc(1'b1, 1'b1, 2'd0, 32'hF);
    rd(2'd0, 2);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 7) == 0);
      if (a == 2'd1) d = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 9));
      else d = $urandom;
      cyc(($urandom_range(0, 199) == 0), w, a, d);
    end

    @(negedge clk);
    bus.WE = 1'b0;
    @(negedge clk);
    #4;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard drain: got %0d left expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
